// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Shared controller definitions: opcodes, ALUOp codes, main FSM
//            state encoding and the control-word struct.
// Revision : 1.0  initial release
// ============================================================================
package riscv_ctrl_pkg;

  localparam int OP_W = 7;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } mainfsm_state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/riscv_mainfsm_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mainfsm_if
// Purpose  : Opcode in / control lines out between main FSM and datapath.
//            Carries 'illegal' when RISCV_MAINFSM_ILLEGAL_TRAP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface riscv_mainfsm_if;
  import riscv_ctrl_pkg::*;

  logic [OP_W-1:0] op;
  logic [1:0]      ALUOp;
  logic [1:0]      ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ResultSrc;
  logic            AdrSrc;
  logic            IRWrite;
  logic            PCUpdate;
  logic            RegWrite;
  logic            MemWrite;
  logic            Branch;
`ifdef RISCV_MAINFSM_ILLEGAL_TRAP_EN
  logic            illegal;
`endif

  modport master (
    input  op,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
    output IRWrite, PCUpdate, RegWrite, MemWrite, Branch
`ifdef RISCV_MAINFSM_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output op,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
    input  IRWrite, PCUpdate, RegWrite, MemWrite, Branch
`ifdef RISCV_MAINFSM_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

endinterface
`default_nettype wire

// File: rtl/riscv_mainfsm_outdec.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mainfsm_outdec
// Purpose  : Combinational state -> control-word decoder for the main FSM.
// Revision : 1.0  initial release
// ============================================================================
module riscv_mainfsm_outdec
  import riscv_ctrl_pkg::*;
(
  input  mainfsm_state_t i_state,
  output ctrl_t          o_ctrl
);

  // TRAP and unused encodings fall through to the all-zero word.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.ir_write   = 1'b1;
        o_ctrl.pc_update  = 1'b1;
        o_ctrl.alu_src_b  = 2'b10;
        o_ctrl.result_src = 2'b10;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = 2'b01;
        o_ctrl.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 2'b10;
        o_ctrl.alu_src_b = 2'b01;
      end
      S_MEMREAD: o_ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        o_ctrl.result_src = 2'b01;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_ctrl.adr_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        o_ctrl.alu_src_a = 2'b10;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        o_ctrl.alu_src_a = 2'b10;
        o_ctrl.alu_src_b = 2'b01;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: o_ctrl.reg_write = 1'b1;
      S_JAL: begin
        o_ctrl.alu_src_a = 2'b01;
        o_ctrl.alu_src_b = 2'b10;
        o_ctrl.pc_update = 1'b1;
      end
      S_BEQ: begin
        o_ctrl.alu_src_a = 2'b10;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.branch    = 1'b1;
      end
      default: o_ctrl.alu_op = ALUOP_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_mainfsm.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mainfsm
// Purpose  : Moore main controller for the multicycle RISC-V datapath.
//            RISCV_MAINFSM_ILLEGAL_TRAP_EN adds a sticky TRAP state + 'illegal'.
// Revision : 1.0  initial release
// ============================================================================
module riscv_mainfsm
  import riscv_ctrl_pkg::*;
(
  input  wire               clk,
  input  wire               reset,
  riscv_mainfsm_if.master   bus
);

  mainfsm_state_t r_state;
  mainfsm_state_t w_next;
  ctrl_t          w_ctrl;
  logic           w_we_ok;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
`ifdef RISCV_MAINFSM_ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      // Anything other than sw goes to MEMREAD, matching the lw path.
      S_MEMADR:   w_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
`ifdef RISCV_MAINFSM_ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  riscv_mainfsm_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Write enables are suppressed while reset is high so an aborted
  // instruction never commits anything in the reset cycle.
  assign w_we_ok = ~reset;

  assign bus.ALUOp     = w_ctrl.alu_op;
  assign bus.ALUSrcA   = w_ctrl.alu_src_a;
  assign bus.ALUSrcB   = w_ctrl.alu_src_b;
  assign bus.ResultSrc = w_ctrl.result_src;
  assign bus.AdrSrc    = w_ctrl.adr_src;
  assign bus.IRWrite   = w_ctrl.ir_write  & w_we_ok;
  assign bus.PCUpdate  = w_ctrl.pc_update & w_we_ok;
  assign bus.RegWrite  = w_ctrl.reg_write & w_we_ok;
  assign bus.MemWrite  = w_ctrl.mem_write & w_we_ok;
  assign bus.Branch    = w_ctrl.branch    & w_we_ok;
`ifdef RISCV_MAINFSM_ILLEGAL_TRAP_EN
  assign bus.illegal   = (r_state == S_TRAP) & w_we_ok;
`endif

endmodule
`default_nettype wire
